// File: rtl/wasm_leb128_reader_if.sv
// wasm_leb128_reader_if -- request/result and ROM byte-port bundle for wasm_leb128_reader (rev 1.0)
`default_nettype none

interface wasm_leb128_reader_if;
  logic        req;
  logic [31:0] start_addr;
  logic        signed_mode;
  logic [31:0] rom_addr;
  logic        rom_read_en;
  logic [7:0]  rom_data;
  logic        rom_ready;
  logic        busy;
  logic        valid;
  logic        error;
  logic [31:0] value;
  logic [2:0]  len;
  logic [31:0] next_addr;

  modport slave (
    input  req, start_addr, signed_mode, rom_data, rom_ready,
    output rom_addr, rom_read_en, busy, valid, error, value, len, next_addr
  );

  modport master (
    output req, start_addr, signed_mode, rom_data, rom_ready,
    input  rom_addr, rom_read_en, busy, valid, error, value, len, next_addr
  );
endinterface

`default_nettype wire

// File: rtl/wasm_leb128_reader.sv
// wasm_leb128_reader -- ROM byte fetch + 32-bit LEB128 decode with a one-entry byte cache (rev 1.0)
// Define WASM_LEB_SIGNED_EN to honour signed_mode (sign-extension and signed 5th-byte range check).
`default_nettype none

module wasm_leb128_reader #(
  parameter int MAX_BYTES = 5
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  wasm_leb128_reader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam logic [2:0] C_LAST_IDX = 3'(MAX_BYTES - 1);

  state_t      r_state;
  logic [31:0] r_cur_addr;
  logic [31:0] r_acc;
  logic [5:0]  r_shift;
  logic [2:0]  r_count;
  logic        r_cache_vld;
  logic [31:0] r_cache_tag;
  logic [7:0]  r_cache_data;
  logic [31:0] r_rom_addr;
  logic        r_rom_read_en;
  logic        r_busy;
  logic        r_valid;
  logic        r_error;
  logic [31:0] r_value;
  logic [2:0]  r_len;
  logic [31:0] r_next_addr;
`ifdef WASM_LEB_SIGNED_EN
  logic        r_signed;
`else
  logic        w_unused_signed;
  assign w_unused_signed = bus.signed_mode;
`endif

  logic        w_hit;
  logic        w_take;
  logic [7:0]  w_byte;
  logic [31:0] w_acc_next;
  logic [31:0] w_value;
  logic [5:0]  w_shift_next;
  logic [2:0]  w_count_next;
  logic [31:0] w_addr_next;
  logic        w_final;
  logic        w_ovf;
  logic        w_err;

  // A byte is consumed either from the cache in FETCH or from the ROM in WAIT.
  always_comb begin
    w_hit        = r_cache_vld && (r_cache_tag == r_cur_addr);
    w_take       = ((r_state == S_FETCH) && w_hit) || ((r_state == S_WAIT) && bus.rom_ready);
    w_byte       = (r_state == S_FETCH) ? r_cache_data : bus.rom_data;
    w_acc_next   = r_acc | ({25'd0, w_byte[6:0]} << r_shift);
    w_shift_next = r_shift + 6'd7;
    w_count_next = r_count + 3'd1;
    w_addr_next  = r_cur_addr + 32'd1;
    w_final      = (r_count == C_LAST_IDX);
`ifdef WASM_LEB_SIGNED_EN
    w_ovf   = r_signed ? !((w_byte[6:3] == 4'h0) || (w_byte[6:3] == 4'hF))
                       : (w_byte[6:4] != 3'd0);
    w_value = w_acc_next;
    if (r_signed && (w_shift_next < 6'd32) && w_byte[6])
      w_value = w_acc_next | (32'hFFFF_FFFF << w_shift_next);
`else
    w_ovf   = (w_byte[6:4] != 3'd0);
    w_value = w_acc_next;
`endif
    w_err = w_final && (w_byte[7] || w_ovf);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cur_addr    <= 32'd0;
      r_acc         <= 32'd0;
      r_shift       <= 6'd0;
      r_count       <= 3'd0;
      r_cache_vld   <= 1'b0;
      r_cache_tag   <= 32'd0;
      r_cache_data  <= 8'd0;
      r_rom_addr    <= 32'd0;
      r_rom_read_en <= 1'b0;
      r_busy        <= 1'b0;
      r_valid       <= 1'b0;
      r_error       <= 1'b0;
      r_value       <= 32'd0;
      r_len         <= 3'd0;
      r_next_addr   <= 32'd0;
`ifdef WASM_LEB_SIGNED_EN
      r_signed      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req) begin
            r_cur_addr <= bus.start_addr;
            r_acc      <= 32'd0;
            r_shift    <= 6'd0;
            r_count    <= 3'd0;
            r_busy     <= 1'b1;
`ifdef WASM_LEB_SIGNED_EN
            r_signed   <= bus.signed_mode;
`endif
            r_state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (!w_hit) begin
            r_rom_addr    <= r_cur_addr;
            r_rom_read_en <= 1'b1;
            r_state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.rom_ready) begin
            r_rom_read_en <= 1'b0;
            r_cache_vld   <= 1'b1;
            r_cache_tag   <= r_cur_addr;
            r_cache_data  <= bus.rom_data;
          end
        end
        S_DONE: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_ERR: begin
          r_error <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // Shared byte-consume path; overrides the FETCH/WAIT next state above.
      if (w_take) begin
        r_acc      <= w_acc_next;
        r_shift    <= w_shift_next;
        r_count    <= w_count_next;
        r_cur_addr <= w_addr_next;
        if (w_err) begin
          r_error     <= 1'b1;
          r_value     <= 32'd0;
          r_len       <= w_count_next;
          r_next_addr <= w_addr_next;
          r_state     <= S_ERR;
        end else if (!w_byte[7]) begin
          r_valid     <= 1'b1;
          r_value     <= w_value;
          r_len       <= w_count_next;
          r_next_addr <= w_addr_next;
          r_state     <= S_DONE;
        end else begin
          r_state <= S_FETCH;
        end
      end
    end
  end

  assign bus.rom_addr    = r_rom_addr;
  assign bus.rom_read_en = r_rom_read_en;
  assign bus.busy        = r_busy;
  assign bus.valid       = r_valid;
  assign bus.error       = r_error;
  assign bus.value       = r_value;
  assign bus.len         = r_len;
  assign bus.next_addr   = r_next_addr;

endmodule

`default_nettype wire

// File: tb/tb_wasm_leb128_reader.sv
// tb_wasm_leb128_reader -- scoreboard bench: directed LEB128 cases plus randomized decodes vs. an arithmetic model (rev 1.0)
`default_nettype none

module tb_wasm_leb128_reader;

  localparam int MAX_BYTES = 5;
`ifdef WASM_LEB_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  typedef struct {
    bit          is_err;
    logic [31:0] value;
    logic [2:0]  len;
    logic [31:0] next_addr;
    longint      lat;
    int          misses;
    longint      req_cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  wasm_leb128_reader_if bus();

  wasm_leb128_reader #(.MAX_BYTES(MAX_BYTES)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:255];
  longint     cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  exp_t       sb[$];

  // Reference-model view of the one-entry cache.
  bit          m_cvld = 1'b0;
  logic [31:0] m_ctag = 32'd0;
  logic [7:0]  m_cdata = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  // ROM: answers one read request with a one-cycle rom_ready pulse one cycle later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rom_ready <= 1'b0;
      bus.rom_data  <= 8'd0;
    end else begin
      bus.rom_ready <= bus.rom_read_en && !bus.rom_ready;
      if (bus.rom_read_en && !bus.rom_ready)
        bus.rom_data <= mem[bus.rom_addr[7:0]];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input bit is_err, input logic [31:0] v, input int len,
                              input logic [31:0] nxt, input int lat, input int misses);
    exp_t e;
    e.is_err = is_err; e.value = v; e.len = 3'(len); e.next_addr = nxt;
    e.lat = lat; e.misses = misses; e.req_cyc = 0;
    return e;
  endfunction

  // Decode as a number: sum of 7-bit groups, then range-check the result.
  function automatic exp_t model(input logic [31:0] start, input bit sgn);
    exp_t        e;
    longint      acc;
    longint      sv;
    logic [31:0] a;
    logic [7:0]  b;
    int          hits;
    int          misses;
    int          n;
    bit          fin;
    acc = 0; a = start; hits = 0; misses = 0; n = 0; fin = 0; b = 8'd0;
    e.is_err = 1'b0;
    while (!fin) begin
      if (m_cvld && m_ctag == a) begin
        b = m_cdata; hits++;
      end else begin
        b = mem[a[7:0]]; misses++;
        m_cvld = 1'b1; m_ctag = a; m_cdata = b;
      end
      acc = acc + (longint'(b[6:0]) << (7 * n));
      n++;
      a = a + 32'd1;
      if (!b[7]) fin = 1;
      else if (n == MAX_BYTES) begin e.is_err = 1'b1; fin = 1; end
    end
    e.value = 32'd0;
    if (!e.is_err) begin
      if (sgn && SIGNED_EN) begin
        sv = acc;
        if (b[6]) sv = acc - (64'sd1 << (7 * n));
        if (sv < -64'sd2147483648 || sv > 64'sd2147483647) e.is_err = 1'b1;
        else e.value = sv[31:0];
      end else begin
        if (acc > 64'sd4294967295) e.is_err = 1'b1;
        else e.value = acc[31:0];
      end
    end
    e.len = 3'(n);
    e.next_addr = a;
    e.lat = 3 * misses + hits + 1;
    e.misses = misses;
    e.req_cyc = 0;
    return e;
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 100 && bus.busy; i++) @(negedge clk);
    if (bus.busy) begin
      n_checks++; n_fail++;
      $display("FAIL wait_idle: busy still 1 after 100 cycles, required 0");
    end
  endtask

  task automatic issue(input logic [31:0] start, input bit sgn, input bit use_c,
                       input exp_t ce, input bit poke);
    exp_t e;
    wait_idle();
    @(negedge clk);
    e = model(start, sgn);
    if (use_c) e = ce;
    e.req_cyc = cyc;
    sb.push_back(e);
    bus.req = 1'b1; bus.start_addr = start; bus.signed_mode = sgn;
    @(negedge clk);
    bus.req = 1'b0;
    if (poke) begin
      @(negedge clk);
      bus.req = 1'b1; bus.start_addr = 32'h80 + 32'($urandom_range(0, 100));
      @(negedge clk);
      bus.req = 1'b0;
    end
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL completion_timeout: start 0x%0h got no valid/error in 300 cycles", start);
      sb.delete();
    end
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_rom_read_en"}, bus.rom_read_en, 0);
    chk({tag, "_rom_addr"},    bus.rom_addr, 0);
    chk({tag, "_busy"},        bus.busy, 0);
    chk({tag, "_valid"},       bus.valid, 0);
    chk({tag, "_error"},       bus.error, 0);
    chk({tag, "_value"},       bus.value, 0);
    chk({tag, "_len"},         bus.len, 0);
    chk({tag, "_next_addr"},   bus.next_addr, 0);
  endtask

  // Monitor: pops one expectation per valid/error pulse.
  initial begin
    exp_t e;
    int   rises;
    bit   prev_re;
    rises = 0; prev_re = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rises = 0; prev_re = 1'b0;
      end else begin
        if (bus.rom_read_en && !prev_re) rises++;
        prev_re = bus.rom_read_en;
        if (bus.valid || bus.error) begin
          if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL spurious_completion: valid=%0d error=%0d value=0x%0h with nothing outstanding",
                     bus.valid, bus.error, bus.value);
          end else begin
            e = sb.pop_front();
            chk("valid",     bus.valid, !e.is_err);
            chk("error",     bus.error, e.is_err);
            chk("value",     bus.value, e.value);
            chk("len",       bus.len, e.len);
            chk("next_addr", bus.next_addr, e.next_addr);
            chk("latency",   cyc - e.req_cyc, e.lat);
            chk("rom_reads", rises, e.misses);
            chk("busy_at_completion", bus.busy, 1);
          end
          rises = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        none;
    logic [31:0] s;
    logic [31:0] a;
    int          l;
    none = mk(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    bus.req = 1'b0; bus.start_addr = 32'd0; bus.signed_mode = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h10] = 8'h1A;
    mem[8'h20] = 8'hE5; mem[8'h21] = 8'h8E; mem[8'h22] = 8'h26;
    mem[8'h30] = 8'hFF; mem[8'h31] = 8'hFF; mem[8'h32] = 8'hFF; mem[8'h33] = 8'hFF; mem[8'h34] = 8'h0F;
    for (int i = 0; i < 5; i++) mem[8'h40 + i] = 8'h80;
    mem[8'h50] = 8'h7F;
    mem[8'hFF] = 8'h81; mem[8'h00] = 8'h01;
    repeat (2) @(negedge clk);
    rst_chk("por");
    rst_n = 1'b1;
    @(negedge clk);

    issue(32'h10, 0, 1, mk(0, 32'h1A, 1, 32'h11, 4, 1), 0);
    issue(32'h10, 0, 1, mk(0, 32'h1A, 1, 32'h11, 2, 0), 0);
    issue(32'h20, 0, 1, mk(0, 32'h0009_8765, 3, 32'h23, 10, 3), 1);
    issue(32'h30, 0, 1, mk(0, 32'hFFFF_FFFF, 5, 32'h35, 16, 5), 0);
    mem[8'h34] = 8'h1F;
    issue(32'h30, 0, 1, mk(1, 32'h0, 5, 32'h35, 16, 5), 0);
    issue(32'h40, 0, 1, mk(1, 32'h0, 5, 32'h45, 16, 5), 0);
`ifdef WASM_LEB_SIGNED_EN
    issue(32'h50, 1, 1, mk(0, 32'hFFFF_FFFF, 1, 32'h51, 4, 1), 0);
`else
    issue(32'h50, 1, 1, mk(0, 32'h7F, 1, 32'h51, 4, 1), 0);
`endif
    issue(32'hFFFF_FFFF, 0, 1, mk(0, 32'h81, 2, 32'h1, 7, 2), 0);

    // Abort a decode while it waits on the ROM.
    wait_idle();
    @(negedge clk);
    bus.req = 1'b1; bus.start_addr = 32'h20; bus.signed_mode = 1'b0;
    @(negedge clk);
    bus.req = 1'b0;
    for (int i = 0; i < 20 && !bus.rom_read_en; i++) @(negedge clk);
    chk("abort_in_wait", bus.rom_read_en, 1);
    #1 rst_n = 1'b0;
    m_cvld = 1'b0;
    #1 rst_chk("mid_reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    issue(32'h20, 0, 1, mk(0, 32'h0009_8765, 3, 32'h23, 10, 3), 0);

    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 3) == 0 && m_cvld) s = m_ctag;
      else s = 32'h80 + 32'($urandom_range(0, 100));
      if ($urandom_range(0, 2) != 0) begin
        l = $urandom_range(1, 6);
        for (int i = 0; i < 6; i++) begin
          a = s + 32'(i);
          if (i < l - 1 || l == 6) mem[a[7:0]] = 8'h80 | 8'($urandom_range(0, 127));
          else if (i == l - 1) begin
            if (l == 5 && $urandom_range(0, 1) == 0) mem[a[7:0]] = 8'($urandom_range(0, 15));
            else mem[a[7:0]] = 8'($urandom_range(0, 127));
          end
        end
      end
      issue(s, 1'($urandom_range(0, 1)), 0, none, $urandom_range(0, 3) == 0);
    end

    wait_idle();
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wasm_leb128_reader.md
# wasm_leb128_reader

Byte-fetch and LEB128 decode stage sitting directly upstream of the `wasm` section parser, between it and the byte-wide `rom` port. On a request it walks ROM bytes from a start address over the `read_en`/`ready` handshake, assembles one unsigned (optionally signed) 32-bit LEB128 integer, and returns the value, its encoded length and the address of the following byte. A one-entry byte cache covers the ROM's refusal to re-answer a repeated address.

## Interface
Parameters:
- `MAX_BYTES`, 5, maximum encoded length accepted for a 32-bit value

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req`  in  1  start decode; sampled only in IDLE
- `start_addr`  in  32  address of the first LEB128 byte; sampled with `req`
- `signed_mode`  in  1  sign-extend result; sampled with `req` (ignored unless `WASM_LEB_SIGNED_EN`)
- `rom_addr`  out  32  ROM byte address
- `rom_read_en`  out  1  ROM read request
- `rom_data`  in  8  ROM byte, valid when `rom_ready`=1
- `rom_ready`  in  1  one-cycle pulse, ROM byte valid
- `busy`  out  1  decode in progress
- `valid`  out  1  one-cycle pulse, `value`/`len`/`next_addr` valid
- `error`  out  1  one-cycle pulse, malformed encoding; `next_addr` valid
- `value`  out  32  decoded integer
- `len`  out  3  encoded byte count, 1..5
- `next_addr`  out  32  `start_addr + len`

## Operation
- States: IDLE, FETCH, WAIT, DONE, ERR.
- IDLE: `busy`=0. On `req`: latch `start_addr` into `cur_addr`, clear accumulator, `shift`=0, `count`=0 -> FETCH.
- FETCH: if cache valid and cache tag == `cur_addr`, take cached byte this cycle (no ROM access); else drive `rom_addr`=`cur_addr`, `rom_read_en`=1 -> WAIT.
- WAIT: hold `rom_addr`, `rom_read_en`=1 until `rom_ready`; then load cache (tag=`cur_addr`, data=`rom_data`), deassert `rom_read_en`, process byte.
- Byte processing: `acc |= byte[6:0] << shift`; `shift += 7`; `count += 1`; `cur_addr += 1`. bit7=1 and `count` < `MAX_BYTES` -> FETCH. bit7=0 -> DONE. bit7=1 at `count`==`MAX_BYTES` -> ERR.
- Overflow check on 5th byte: unsigned requires `byte[6:4]`==0, else ERR.
- DONE: `valid`=1 for one cycle, `value`=acc, `len`=`count`, `next_addr`=`cur_addr` -> IDLE.
- ERR: `error`=1 for one cycle, `value`=0, `len`=`count`, `next_addr`=`cur_addr` -> IDLE.
- `value`, `len`, `next_addr` hold after DONE/ERR until the next completion.
- `req` while busy ignored; no queuing.
- Address arithmetic wraps modulo 2^32 (0xFFFFFFFF+1 = 0).

## Timing
- Reset (asynchronous, `rst_n`=0): state IDLE; `rom_read_en`=0, `rom_addr`=0, `busy`=0, `valid`=0, `error`=0, `value`=0, `len`=0, `next_addr`=0, cache invalid.
- Reset mid-fetch: `rom_read_en` drops immediately; partial result discarded; no `valid`/`error`.
- ROM miss: `rom_read_en` first asserted the cycle after the FETCH edge; ROM raises `rom_ready` one cycle later; byte consumed on that edge. 3 cycles/byte including FETCH.
- Cache hit: 1 cycle/byte, `rom_read_en` stays 0.
- `req` -> `valid`: 3·N_miss + N_hit + 1 cycles (1-byte miss: `valid` 4 cycles after `req` edge).
- `busy`=1 from the cycle after `req` through the DONE/ERR cycle inclusive.
- `rom_ready` outside WAIT ignored.

## Configuration
- `WASM_LEB_SIGNED_EN` defined: `signed_mode`=1 sign-extends from bit (`shift`-1) after the final byte when `shift` < 32; 5th-byte check requires `byte[6:3]` ∈ {0000, 1111}, else ERR.
- Undefined: `signed_mode` ignored, all decodes unsigned; no sign-extension logic.

## Test plan
- ROM[0x10]=0x1A, `req` start 0x10 -> `valid`, `value`=0x1A, `len`=1, `next_addr`=0x11, `valid` 4 cycles after `req`.
- ROM[0x20..0x22]=E5 8E 26 -> `value`=0x00098765, `len`=3, `next_addr`=0x23; exactly three `rom_read_en` episodes.
- ROM[0x30..0x34]=FF FF FF FF 0F -> `value`=0xFFFFFFFF, `len`=5; same with last byte 0x1F -> `error`, `len`=5, no `valid`.
- ROM[0x40..0x44]=80 80 80 80 80 -> `error` after 5th byte, `next_addr`=0x45, no 6th read.
- Decode at 0x10 (0x1A), then `req` again at 0x10 -> `valid`, `value`=0x1A in 2 cycles, `rom_read_en` never asserted.
- `rst_n` low during WAIT of a 3-byte decode -> all outputs at reset values, no `valid`; new `req` at 0x20 -> `value`=0x00098765.
- With `WASM_LEB_SIGNED_EN`, `signed_mode`=1, ROM byte 0x7F -> `value`=0xFFFFFFFF, `len`=1.
